// File: rtl/filt_ppi_requant.sv
// Output requantizer for the polyphase interpolator: arithmetic right shift with
// optional convergent rounding, saturation to the output word, polyphase index
// tagging, slow-clock strobe regeneration and saturation statistics.
// Two-stage pipeline (round, saturate); every state element advances only when i_ena=1.
module filt_ppi_requant #(
    parameter int gp_idata_width          = 20,
    parameter int gp_odata_width          = 12,
    parameter int gp_shift                = 6,
    parameter int gp_rnd_mode             = 1,
    parameter int gp_interpolation_factor = 4,
    parameter int gp_phase_width          = 2,
    parameter int gp_satcnt_width         = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_ena,
    input  logic                              i_valid,
    input  logic                              i_sync,
    input  logic                              i_clr_flags,
    input  logic signed [gp_idata_width-1:0]  i_data,
    output logic signed [gp_odata_width-1:0]  o_data,
    output logic                              o_valid,
    output logic        [gp_phase_width-1:0]  o_phase,
    output logic                              o_sclk,
    output logic                              o_sat,
    output logic                              o_sat_sticky,
    output logic        [gp_satcnt_width-1:0] o_sat_cnt
);

    // Rounded value carries one extra MSB so the +1 increment can never wrap.
    localparam int W1 = gp_idata_width - gp_shift + 1;

    localparam int unsigned PH_LAST_I = gp_interpolation_factor - 1;
    localparam logic [gp_phase_width-1:0] PH_LAST  = PH_LAST_I[gp_phase_width-1:0];
    localparam logic [gp_phase_width-1:0] PH_AFTER_SYNC =
        (gp_interpolation_factor == 1) ? '0 : {{(gp_phase_width-1){1'b0}}, 1'b1};

    localparam logic [gp_odata_width-1:0] SAT_MAX = {1'b0, {(gp_odata_width-1){1'b1}}};
    localparam logic [gp_odata_width-1:0] SAT_MIN = {1'b1, {(gp_odata_width-1){1'b0}}};

    logic signed [W1-1:0]              rnd_val;
    logic        [gp_phase_width-1:0]  ph_cnt;
    logic        [gp_phase_width-1:0]  ph_next;
    logic        [gp_phase_width-1:0]  ph_tag;

    logic signed [W1-1:0]              s1_data;
    logic                              s1_valid;
    logic        [gp_phase_width-1:0]  s1_phase;

    logic        [gp_odata_width-1:0]  sat_val;
    logic                              ovf;
    logic                              sat_evt;

    generate
        if (gp_shift == 0) begin : g_noshift
            // No LSBs discarded: pass through sign-extended, rounding bypassed.
            always_comb rnd_val = {i_data[gp_idata_width-1], i_data};
        end else begin : g_shift
            localparam int unsigned HALF_I = 1 << (gp_shift - 1);
            localparam logic [gp_shift-1:0] HALF = HALF_I[gp_shift-1:0];

            logic signed [W1-1:0]  kept;
            logic [gp_shift-1:0]   frac;
            logic                  inc;

            // Arithmetic shift plus round-half-even increment (or plain floor).
            always_comb begin
                kept = {{2{i_data[gp_idata_width-1]}}, i_data[gp_idata_width-1:gp_shift]};
                frac = i_data[gp_shift-1:0];
                inc  = 1'b0;
                if (gp_rnd_mode == 1) begin
                    if ((frac > HALF) || ((frac == HALF) && kept[0]))
                        inc = 1'b1;
                end
                rnd_val = kept + {{(W1-1){1'b0}}, inc};
            end
        end
    endgenerate

    // Phase tag for the incoming sample and the counter value after accepting it.
    always_comb begin
        ph_tag  = i_sync ? '0 : ph_cnt;
        ph_next = '0;
        if (i_sync)
            ph_next = PH_AFTER_SYNC;
        else if (ph_cnt != PH_LAST)
            ph_next = ph_cnt + 1'b1;
    end

    // Stage 1: register rounded sample, its phase tag, and advance the phase counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_phase <= '0;
            ph_cnt   <= '0;
        end else if (i_ena) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_data  <= rnd_val;
                s1_phase <= ph_tag;
                ph_cnt   <= ph_next;
            end
        end
    end

    // Overflow when the bits above the output sign bit are not all sign copies.
    always_comb begin
        ovf     = !((&s1_data[W1-1:gp_odata_width-1]) || !(|s1_data[W1-1:gp_odata_width-1]));
        sat_val = s1_data[gp_odata_width-1:0];
        if (ovf)
            sat_val = s1_data[W1-1] ? SAT_MIN : SAT_MAX;
        sat_evt = s1_valid && ovf;
    end

    // Stage 2: saturated output register; data and phase hold across bubbles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_phase <= '0;
            o_sclk  <= 1'b0;
            o_sat   <= 1'b0;
        end else if (i_ena) begin
            o_valid <= s1_valid;
            o_sat   <= sat_evt;
            o_sclk  <= s1_valid && (s1_phase == '0);
            if (s1_valid) begin
                o_data  <= sat_val;
                o_phase <= s1_phase;
            end
        end
    end

    // Saturation statistics, updated with the clipped sample entering the output
    // register so a clear in that same cycle still records the event.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sat_sticky <= 1'b0;
            o_sat_cnt    <= '0;
        end else if (i_ena) begin
            if (i_clr_flags) begin
                o_sat_sticky <= sat_evt;
                o_sat_cnt    <= {{(gp_satcnt_width-1){1'b0}}, sat_evt};
            end else if (sat_evt) begin
                o_sat_sticky <= 1'b1;
                if (o_sat_cnt != '1)
                    o_sat_cnt <= o_sat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_filt_ppi_requant.sv
// Directed self-checking bench for filt_ppi_requant (default parameters plus a
// truncating instance fed with the same stimulus).
module tb_filt_ppi_requant;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ena = 1'b1;
    logic               valid = 1'b0;
    logic               sync = 1'b0;
    logic               clr = 1'b0;
    logic signed [19:0] din = '0;

    logic signed [11:0] o_data;
    logic               o_valid;
    logic [1:0]         o_phase;
    logic               o_sclk;
    logic               o_sat;
    logic               o_sat_sticky;
    logic [7:0]         o_sat_cnt;

    logic signed [11:0] t_data;
    logic               t_valid;
    logic [1:0]         t_phase;
    logic               t_sclk;
    logic               t_sat;
    logic               t_sat_sticky;
    logic [7:0]         t_sat_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    filt_ppi_requant dut (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_valid(valid), .i_sync(sync),
        .i_clr_flags(clr), .i_data(din),
        .o_data(o_data), .o_valid(o_valid), .o_phase(o_phase), .o_sclk(o_sclk),
        .o_sat(o_sat), .o_sat_sticky(o_sat_sticky), .o_sat_cnt(o_sat_cnt)
    );

    filt_ppi_requant #(.gp_rnd_mode(0)) dut_t (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_valid(valid), .i_sync(sync),
        .i_clr_flags(clr), .i_data(din),
        .o_data(t_data), .o_valid(t_valid), .o_phase(t_phase), .o_sclk(t_sclk),
        .o_sat(t_sat), .o_sat_sticky(t_sat_sticky), .o_sat_cnt(t_sat_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0;
        step(); step();
        total++;
        if ({o_data, o_valid, o_phase, o_sclk, o_sat, o_sat_sticky, o_sat_cnt} !== '0)
            $display("FAIL reset_outputs: got data=%0d v=%b ph=%0d sclk=%b sat=%b st=%b cnt=%0d, want all 0",
                     o_data, o_valid, o_phase, o_sclk, o_sat, o_sat_sticky, o_sat_cnt);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_rounding();
        int vin[5]  = '{96, 160, 224, -96, -160};
        int vexp[5] = '{2, 2, 4, -2, -2};
        int texp[5] = '{1, 2, 3, -2, -3};
        for (int i = 0; i < 7; i++) begin
            valid = (i < 5);
            din   = (i < 5) ? 20'(vin[i]) : '0;
            step();
            if (i == 0) begin
                total++;
                if (o_valid !== 1'b0) $display("FAIL rnd_latency: o_valid=%b after 1 cycle, want 0", o_valid);
                else passed++;
            end else if (i <= 5) begin
                total++;
                if (o_valid !== 1'b1 || int'(o_data) !== vexp[i-1] || o_sat !== 1'b0)
                    $display("FAIL rnd_%0d: got v=%b data=%0d sat=%b, want v=1 data=%0d sat=0",
                             vin[i-1], o_valid, o_data, o_sat, vexp[i-1]);
                else passed++;
                total++;
                if (int'(t_data) !== texp[i-1])
                    $display("FAIL trunc_%0d: got %0d, want %0d", vin[i-1], t_data, texp[i-1]);
                else passed++;
            end
        end
    endtask

    task automatic test_saturation();
        int vin[3]  = '{524287, -524288, 131040};
        int vexp[3] = '{2047, -2048, 2047};
        for (int i = 0; i < 4; i++) begin
            valid = (i < 3);
            din   = (i < 3) ? 20'(vin[i]) : '0;
            step();
            if (i >= 1) begin
                total++;
                if (o_valid !== 1'b1 || int'(o_data) !== vexp[i-1] || o_sat !== 1'b1)
                    $display("FAIL sat_%0d: got v=%b data=%0d sat=%b, want v=1 data=%0d sat=1",
                             vin[i-1], o_valid, o_data, o_sat, vexp[i-1]);
                else passed++;
            end
        end
        valid = 1'b0;
        step();
        total++;
        if (o_sat_cnt !== 8'd3 || o_sat_sticky !== 1'b1 || o_sat !== 1'b0)
            $display("FAIL sat_stats: got cnt=%0d sticky=%b sat=%b, want cnt=3 sticky=1 sat=0",
                     o_sat_cnt, o_sat_sticky, o_sat);
        else passed++;
        // clear coincident with a clip entering the output register
        valid = 1'b1; din = 20'sd524287;
        step();
        valid = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        total++;
        if (o_sat_cnt !== 8'd1 || o_sat_sticky !== 1'b1)
            $display("FAIL clr_with_clip: got cnt=%0d sticky=%b, want cnt=1 sticky=1", o_sat_cnt, o_sat_sticky);
        else passed++;
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++;
        if (o_sat_cnt !== 8'd0 || o_sat_sticky !== 1'b0)
            $display("FAIL clr_alone: got cnt=%0d sticky=%b, want cnt=0 sticky=0", o_sat_cnt, o_sat_sticky);
        else passed++;
    endtask

    task automatic test_phase();
        int gaps[9]  = '{0, 2, 1, 3, 0, 1, 2, 0, 3};
        int phexp[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        bit cv[64];
        bit cs[64];
        int cd[64];
        int n = 0;
        int k = 0;
        bit prev_v = 1'b0;
        for (int s = 0; s < 9; s++) begin
            for (int g = 0; g < gaps[s]; g++) begin
                cv[n] = 1'b0; cs[n] = 1'b0; cd[n] = 0; n++;
            end
            cv[n] = 1'b1; cs[n] = (s == 0); cd[n] = s * 64; n++;
        end
        for (int c = 0; c < n + 2; c++) begin
            valid = (c < n) ? cv[c] : 1'b0;
            sync  = (c < n) ? cs[c] : 1'b0;
            din   = (c < n) ? 20'(cd[c]) : '0;
            step();
            total++;
            if (o_valid !== prev_v) $display("FAIL phase_valid_c%0d: got %b, want %b", c, o_valid, prev_v);
            else passed++;
            if (prev_v) begin
                total++;
                if (int'(o_phase) !== phexp[k] || o_sclk !== (phexp[k] == 0) || int'(o_data) !== k)
                    $display("FAIL phase_out%0d: got ph=%0d sclk=%b data=%0d, want ph=%0d sclk=%b data=%0d",
                             k + 1, o_phase, o_sclk, o_data, phexp[k], (phexp[k] == 0), k);
                else passed++;
                k++;
            end else begin
                total++;
                if (o_sclk !== 1'b0) $display("FAIL phase_bubble_sclk_c%0d: got %b, want 0", c, o_sclk);
                else passed++;
            end
            prev_v = (c < n) ? cv[c] : 1'b0;
        end
        sync = 1'b0;
    endtask

    task automatic test_resync();
        bit cv[8] = '{1, 1, 1, 1, 0, 1, 1, 1};
        bit cs[8] = '{1, 0, 1, 0, 1, 0, 0, 0};
        int phexp[7] = '{0, 1, 0, 1, 2, 3, 0};
        int k = 0;
        int d = 0;
        bit prev_v = 1'b0;
        for (int c = 0; c < 10; c++) begin
            valid = (c < 8) ? cv[c] : 1'b0;
            sync  = (c < 8) ? cs[c] : 1'b0;
            din   = 20'(d * 64);
            if (valid) d++;
            step();
            if (prev_v) begin
                total++;
                if (o_valid !== 1'b1 || int'(o_phase) !== phexp[k] || int'(o_data) !== k)
                    $display("FAIL resync_out%0d: got v=%b ph=%0d data=%0d, want v=1 ph=%0d data=%0d",
                             k + 1, o_valid, o_phase, o_data, phexp[k], k);
                else passed++;
                k++;
            end
            prev_v = (c < 8) ? cv[c] : 1'b0;
        end
        sync = 1'b0;
    endtask

    task automatic test_enable_stall();
        clr = 1'b1; valid = 1'b0;
        step();
        clr = 1'b0;
        valid = 1'b1; din = 20'sd320;
        step();
        din = 20'sd524287;
        step();
        din = 20'sd999;
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (o_valid !== 1'b1 || int'(o_data) !== 5 || o_sat !== 1'b0)
                $display("FAIL stall_freeze%0d: got v=%b data=%0d sat=%b, want v=1 data=5 sat=0",
                         i, o_valid, o_data, o_sat);
            else passed++;
        end
        ena = 1'b1; valid = 1'b0;
        step();
        total++;
        if (o_valid !== 1'b1 || int'(o_data) !== 2047 || o_sat !== 1'b1 || o_sat_cnt !== 8'd1)
            $display("FAIL stall_second: got v=%b data=%0d sat=%b cnt=%0d, want v=1 data=2047 sat=1 cnt=1",
                     o_valid, o_data, o_sat, o_sat_cnt);
        else passed++;
        ena = 1'b0;
        step(); step(); step();
        ena = 1'b1;
        step();
        total++;
        if (o_valid !== 1'b0 || o_sat_cnt !== 8'd1)
            $display("FAIL stall_no_dup: got v=%b cnt=%0d, want v=0 cnt=1", o_valid, o_sat_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        valid = 1'b1; din = 20'sd524287;
        step();
        din = 20'sd128;
        step();
        valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({o_data, o_valid, o_phase, o_sclk, o_sat, o_sat_sticky, o_sat_cnt} !== '0)
            $display("FAIL midreset_outputs: got data=%0d v=%b ph=%0d sclk=%b sat=%b st=%b cnt=%0d, want all 0",
                     o_data, o_valid, o_phase, o_sclk, o_sat, o_sat_sticky, o_sat_cnt);
        else passed++;
        step();
        total++;
        if (o_valid !== 1'b0) $display("FAIL midreset_stale: got v=%b, want 0", o_valid);
        else passed++;
        valid = 1'b1; din = 20'sd192;
        step();
        valid = 1'b0;
        step();
        total++;
        if (o_valid !== 1'b1 || int'(o_data) !== 3 || o_phase !== 2'd0 || o_sclk !== 1'b1)
            $display("FAIL midreset_first: got v=%b data=%0d ph=%0d sclk=%b, want v=1 data=3 ph=0 sclk=1",
                     o_valid, o_data, o_phase, o_sclk);
        else passed++;
    endtask

    task automatic test_satcnt_limit();
        clr = 1'b1; valid = 1'b0;
        step();
        clr = 1'b0;
        valid = 1'b1; din = -20'sd524288;
        for (int i = 0; i < 300; i++) step();
        valid = 1'b0;
        step(); step();
        total++;
        if (o_sat_cnt !== 8'd255 || o_sat_sticky !== 1'b1)
            $display("FAIL satcnt_limit: got cnt=%0d sticky=%b, want cnt=255 sticky=1", o_sat_cnt, o_sat_sticky);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_phase();
        test_resync();
        test_enable_stall();
        test_reset_mid();
        test_satcnt_limit();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/filt_ppi_requant.md
Name: filt_ppi_requant

Overview:
Output requantizer that sits directly downstream of the polyphase interpolator's commutator, on the fast clock. It takes the full-precision interpolated sample stream, scales it by a fixed right shift with convergent rounding, and saturates to the DAC/output word width. It also tags each output sample with its polyphase index, regenerates the slow-clock strobe, and keeps saturation statistics for the system controller.

Parameters:
gp_idata_width, 20, input (commutator output) width, signed
gp_odata_width, 12, output width, signed; must be <= gp_idata_width-gp_shift+1
gp_shift, 6, LSBs discarded (0 = no scaling, rounding bypassed)
gp_rnd_mode, 1, 1 = convergent (round-half-even), 0 = truncate toward -inf
gp_interpolation_factor, 4, phases per input sample
gp_phase_width, 2, width of o_phase; must be >= ceil(log2(gp_interpolation_factor)), minimum 1
gp_satcnt_width, 8, saturation event counter width

Ports:
i_clk  in  1  rising-edge fast clock
i_rst  in  1  synchronous reset, active high
i_ena  in  1  synchronous active-high enable; low freezes all state
i_valid  in  1  i_data qualifier
i_sync  in  1  marks current valid sample as phase 0
i_clr_flags  in  1  clears o_sat_sticky and o_sat_cnt
i_data  in  gp_idata_width  signed interpolated sample
o_data  out  gp_odata_width  signed requantized sample
o_valid  out  1  o_data qualifier
o_phase  out  gp_phase_width  polyphase index of o_data
o_sclk  out  1  high with o_valid when o_phase==0
o_sat  out  1  current o_data was clipped
o_sat_sticky  out  1  any clip since last clear
o_sat_cnt  out  gp_satcnt_width  clip event count, saturating

Behaviour:
- Single clock domain (i_clk); reset synchronous active-high on i_rst; all state updates only on cycles with i_ena=1 (i_rst overrides i_ena).
- Reset: o_data=0, o_valid=0, o_phase=0, o_sclk=0, o_sat=0, o_sat_sticky=0, o_sat_cnt=0, phase counter=0, pipeline valids=0.
- Pipeline, 2 enabled cycles input-to-output. Each stage carries data+valid; bubbles (i_valid=0) propagate as valid=0.
- Stage 1 (round): kept = i_data >>> gp_shift (arithmetic), computed at gp_idata_width-gp_shift+1 bits so rounding never wraps. frac = i_data[gp_shift-1:0], half = 2^(gp_shift-1).
  - gp_rnd_mode=1: +1 if frac>half, or frac==half and kept[0]=1.
  - gp_rnd_mode=0: no increment.
  - Phase tag: 0 if i_sync, else phase counter.
- Stage 2 (saturate): value > 2^(gp_odata_width-1)-1 outputs max with o_sat=1; value < -2^(gp_odata_width-1) outputs min with o_sat=1; otherwise pass with o_sat=0.
  - o_valid, o_phase and o_sclk are registered together with o_data.
  - On o_valid=0: o_data holds its previous value, and o_sat=0, o_sclk=0.
- Phase counter: advances on each accepted sample (i_ena&i_valid); wraps gp_interpolation_factor-1 -> 0.
  - i_sync with i_valid: that sample gets phase 0 and the counter becomes 1 (or 0 if gp_interpolation_factor=1).
  - i_sync without i_valid is ignored.
- Saturation stats, updated on output samples with o_sat=1:
  - o_sat_sticky is set.
  - o_sat_cnt increments and holds at all-ones.
  - i_clr_flags alone: sticky=0, cnt=0.
  - i_clr_flags coincident with a new clip event: sticky=1, cnt=1 (event not lost).
- i_ena=0 mid-stream: pipeline and counters freeze; outputs hold including o_valid (downstream qualifies with i_ena).
- i_rst mid-stream: in-flight samples discarded; first post-reset sample emerges 2 enabled cycles after acceptance with phase 0.

Test Plan:
- Rounding (defaults), i_data = 96, 160, 224, -96, -160 -> o_data = 2, 2, 4, -2, -2 exactly 2 cycles later, o_sat=0; with gp_rnd_mode=0, 96 -> 1 and -96 -> -2.
- Saturation: i_data = 524287 -> o_data=2047, o_sat=1; -524288 -> -2048, o_sat=1; 131040 (->2048 after rounding) -> 2047, o_sat=1; o_sat_cnt=3, sticky=1; pulse i_clr_flags -> 0/0; clear coincident with clip -> cnt=1, sticky=1.
- Phase/strobe: 9 valid samples with random 0-3 cycle gaps -> o_phase 0,1,2,3,0,1,2,3,0; o_sclk high on outputs 1, 5, 9 only; bubbles give o_valid=0.
- Resync: i_sync on 3rd valid sample -> phases 0,1,0,1,2,3,0; sync on a non-valid cycle -> no change.
- Enable stall: drop i_ena for 5 cycles with 2 samples in flight -> outputs frozen; both samples emerge in order with correct values after i_ena returns; no duplicates counted.
- Reset mid-stream: assert i_rst for 1 cycle with pipeline full -> next cycle all outputs 0; no stale samples; o_sat_cnt 255 saturates, not wraps, after 300 clips.
